// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the programmable single-clock FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

   function automatic int count_width(input int ptr_w);
      return ptr_w + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem_2p.sv
// ============================================================================
// Module      : sync_fifo_mem_2p
// Description : Single-clock register array, one write port and one read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_mem_2p #(
   parameter int DATA_WIDTH = 9,
   parameter int ADDR_WIDTH = 9,
   parameter bit REG_OUT    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata <= '0;
            end else if (re) begin
               rdata <= mem[raddr];
            end
         end
      end else begin : g_comb_out
         logic unused_ports;
         assign unused_ports = &{1'b0, re, rst_n};
         assign rdata        = mem[raddr];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo_prog.sv
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with run-time almost-full/empty thresholds,
//               exact fill count, sticky error flags and synchronous flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 9,
   parameter int PTR_WIDTH  = 9,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data_write,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] data_read,
   input  logic [PTR_WIDTH:0]    af_thresh,
   input  logic [PTR_WIDTH:0]    ae_thresh,
   output logic [PTR_WIDTH:0]    fill_count,
   output logic                  wfull,
   output logic                  rempty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int              CW      = count_width(PTR_WIDTH);
   localparam logic [CW-1:0]   DEPTH   = CW'(1 << PTR_WIDTH);
   localparam fifo_mode_e      MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam bit              REG_OUT = (MODE == FIFO_STD);

   logic [PTR_WIDTH-1:0] waddr;
   logic [PTR_WIDTH-1:0] raddr;
   logic [CW-1:0]        count;
   logic [CW-1:0]        next_count;
   logic                 wr_acc;
   logic                 rd_acc;

   // A flush cycle swallows both requests so nothing moves and no error latches.
   assign wr_acc = write_enable & ~wfull  & ~clr;
   assign rd_acc = read_enable  & ~rempty & ~clr;

   always_comb begin
      next_count = count + CW'(wr_acc) - CW'(rd_acc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr <= '0;
         raddr <= '0;
         count <= '0;
      end else if (clr) begin
         waddr <= '0;
         raddr <= '0;
         count <= '0;
      end else begin
         if (wr_acc) begin
            waddr <= waddr + 1'b1;
         end
         if (rd_acc) begin
            raddr <= raddr + 1'b1;
         end
         count <= next_count;
      end
   end

   // Flags look ahead at next_count so they line up with the count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wfull        <= 1'b0;
         rempty       <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else if (clr) begin
         wfull        <= 1'b0;
         rempty       <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wfull        <= (next_count == DEPTH);
         rempty       <= (next_count == '0);
         almost_full  <= (next_count >= af_thresh);
         almost_empty <= (next_count <= ae_thresh);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (write_enable && wfull) begin
            overflow <= 1'b1;
         end
         if (read_enable && rempty) begin
            underflow <= 1'b1;
         end
      end
   end

   assign fill_count = count;

   sync_fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (PTR_WIDTH),
      .REG_OUT    (REG_OUT)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (waddr),
      .wdata (data_write),
      .re    (rd_acc),
      .raddr (raddr),
      .rdata (data_read)
   );

endmodule

`default_nettype wire
